// File: rtl/sga_body_sequencer.sv
// sga_body_sequencer: snake-body engine. Owns the body coordinate store and
// performs one complete move (next head, wall check, self scan, shift, head
// write, optional growth) per accepted `step`, or loads the start pose on `init`.
// Optional build macro: SGA_WRAP_EN -- grid wraps at the edges, no wall hits.
module sga_body_sequencer #(
  parameter int unsigned COORD_W  = 4,
  parameter int unsigned GRID_X   = 16,
  parameter int unsigned GRID_Y   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned INIT_X   = 5,
  parameter int unsigned INIT_Y   = 8
) (
  input  logic                   clock,
  input  logic                   restart_n,
  input  logic                   init,
  input  logic                   step,
  input  logic [1:0]             dir,
  input  logic                   grow,
  output logic                   busy,
  output logic                   done,
  output logic                   wall_hit,
  output logic                   self_hit,
  output logic                   full,
  output logic [ADDR_W:0]        length,
  output logic [COORD_W-1:0]     head_x,
  output logic [COORD_W-1:0]     head_y,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [2*COORD_W-1:0]   rd_data,
  output logic                   rd_valid
);

  localparam int unsigned MAX_LEN = 1 << ADDR_W;
  localparam int unsigned LEN_W   = ADDR_W + 1;

  localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(GRID_X - 1);
  localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(GRID_Y - 1);
  localparam logic [COORD_W-1:0] X_INIT = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] Y_INIT = COORD_W'(INIT_Y);
  localparam logic [ADDR_W-1:0]  INIT_LAST = ADDR_W'(INIT_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_CALC,
    ST_SCAN,
    ST_SHIFT,
    ST_WHEAD,
    ST_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  // Body store; entry 0 is the head. Deliberately not cleared by reset.
  logic [COORD_W-1:0] body_x [MAX_LEN];
  logic [COORD_W-1:0] body_y [MAX_LEN];

  logic [ADDR_W-1:0]  idx_q;
  logic [1:0]         dir_q;
  logic               grow_q;
  logic [COORD_W-1:0] nh_x_q;
  logic [COORD_W-1:0] nh_y_q;

  logic [COORD_W-1:0] nh_x_c;
  logic [COORD_W-1:0] nh_y_c;
  logic               wall_c;
  logic [LEN_W-1:0]   new_len_c;
  logic [ADDR_W-1:0]  span_c;
  logic               match_c;
  logic               accept_step_c;

  // Length after this move and the scan/shift span (new_len-1, zero when empty).
  always_comb begin
    new_len_c = length + LEN_W'(grow_q);
    span_c    = '0;
    if (new_len_c != '0) begin
      span_c = ADDR_W'(new_len_c - LEN_W'(1));
    end
  end

  // Candidate head is compared against the entry currently addressed by the scan.
  always_comb begin
    match_c = (body_x[idx_q] == nh_x_q) && (body_y[idx_q] == nh_y_q);
  end

  // A step is only taken from IDLE and loses to a simultaneous init.
  always_comb begin
    accept_step_c = (state_q == ST_IDLE) && step && !init;
  end

  // Next head from the current head and the latched direction, with edge handling.
  always_comb begin
    nh_x_c = head_x;
    nh_y_c = head_y;
    wall_c = 1'b0;
    case (dir_q)
      2'b00: begin
        if (head_x == X_MAX) begin
`ifdef SGA_WRAP_EN
          nh_x_c = '0;
`else
          wall_c = 1'b1;
`endif
        end else begin
          nh_x_c = head_x + COORD_W'(1);
        end
      end
      2'b01: begin
        if (head_y == Y_MAX) begin
`ifdef SGA_WRAP_EN
          nh_y_c = '0;
`else
          wall_c = 1'b1;
`endif
        end else begin
          nh_y_c = head_y + COORD_W'(1);
        end
      end
      2'b10: begin
        if (head_x == '0) begin
`ifdef SGA_WRAP_EN
          nh_x_c = X_MAX;
`else
          wall_c = 1'b1;
`endif
        end else begin
          nh_x_c = head_x - COORD_W'(1);
        end
      end
      default: begin
        if (head_y == '0) begin
`ifdef SGA_WRAP_EN
          nh_y_c = Y_MAX;
`else
          wall_c = 1'b1;
`endif
        end else begin
          nh_y_c = head_y - COORD_W'(1);
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!restart_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the init and move sequences.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (init) begin
          state_d = ST_INIT;
        end else if (step) begin
          state_d = ST_CALC;
        end
      end
      ST_INIT: begin
        if (idx_q == INIT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (wall_c) begin
          state_d = ST_DONE;
        end else if (span_c == '0) begin
          state_d = ST_WHEAD;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (match_c) begin
          state_d = ST_DONE;
        end else if (idx_q == span_c - ADDR_W'(1)) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (idx_q == ADDR_W'(1)) begin
          state_d = ST_WHEAD;
        end
      end
      ST_WHEAD: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control registers, sequence index and registered status/read outputs.
  always_ff @(posedge clock) begin
    if (!restart_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      wall_hit <= 1'b0;
      self_hit <= 1'b0;
      length   <= '0;
      head_x   <= '0;
      head_y   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      idx_q    <= '0;
      dir_q    <= '0;
      grow_q   <= 1'b0;
      nh_x_q   <= '0;
      nh_y_q   <= '0;
    end else begin
      busy     <= (state_d != ST_IDLE);
      done     <= (state_d == ST_DONE);
      rd_data  <= {body_x[rd_addr], body_y[rd_addr]};
      rd_valid <= ({1'b0, rd_addr} < length);
      case (state_q)
        ST_IDLE: begin
          idx_q <= '0;
          if (accept_step_c) begin
            dir_q    <= dir;
            grow_q   <= grow && !full;
            wall_hit <= 1'b0;
            self_hit <= 1'b0;
          end
        end
        ST_INIT: begin
          idx_q <= idx_q + ADDR_W'(1);
          if (idx_q == '0) begin
            head_x <= X_INIT;
            head_y <= Y_INIT;
          end
          if (state_d == ST_IDLE) begin
            length <= LEN_W'(INIT_LEN);
          end
        end
        ST_CALC: begin
          nh_x_q   <= nh_x_c;
          nh_y_q   <= nh_y_c;
          wall_hit <= wall_c;
          idx_q    <= '0;
        end
        ST_SCAN: begin
          if (match_c) begin
            self_hit <= 1'b1;
          end
          if (state_d == ST_SHIFT) begin
            idx_q <= span_c;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        ST_SHIFT: begin
          idx_q <= idx_q - ADDR_W'(1);
        end
        ST_WHEAD: begin
          head_x <= nh_x_q;
          head_y <= nh_y_q;
          length <= new_len_c;
        end
        default: begin
        end
      endcase
    end
  end

  // Body store writes: start pose, one-entry shift toward the tail, head write.
  always_ff @(posedge clock) begin
    if (restart_n) begin
      case (state_q)
        ST_INIT: begin
          body_x[idx_q] <= X_INIT - COORD_W'(idx_q);
          body_y[idx_q] <= Y_INIT;
        end
        ST_SHIFT: begin
          body_x[idx_q] <= body_x[idx_q - ADDR_W'(1)];
          body_y[idx_q] <= body_y[idx_q - ADDR_W'(1)];
        end
        ST_WHEAD: begin
          body_x[0] <= nh_x_q;
          body_y[0] <= nh_y_q;
        end
        default: begin
        end
      endcase
    end
  end

  // Full flag follows the length register directly.
  assign full = (length == LEN_W'(MAX_LEN));

endmodule

// File: tb/tb_sga_body_sequencer.sv
// Bench for sga_body_sequencer: directed scenarios plus random moves, checked
// against a queue-based snake model (head at the front of the queue).
module tb_sga_body_sequencer;

  localparam int GX   = 16;
  localparam int GY   = 16;
  localparam int MAXL = 16;
  localparam int ILEN = 3;
  localparam int IX   = 5;
  localparam int IY   = 8;

  logic       clock = 1'b0;
  logic       restart_n;
  logic       init;
  logic       step;
  logic [1:0] dir;
  logic       grow;
  logic       busy;
  logic       done;
  logic       wall_hit;
  logic       self_hit;
  logic       full;
  logic [4:0] length;
  logic [3:0] head_x;
  logic [3:0] head_y;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;

  int vectors     = 0;
  int miscompares = 0;

  int mx[$];
  int my[$];

  always #5 clock = ~clock;

  sga_body_sequencer dut (
    .clock     (clock),
    .restart_n (restart_n),
    .init      (init),
    .step      (step),
    .dir       (dir),
    .grow      (grow),
    .busy      (busy),
    .done      (done),
    .wall_hit  (wall_hit),
    .self_hit  (self_hit),
    .full      (full),
    .length    (length),
    .head_x    (head_x),
    .head_y    (head_y),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference move: returns expected latency and hit flags, updates the snake.
  task automatic model_step(input int d, input bit gr, output int lat,
                            output bit wh, output bit sh);
    int nx, ny, k, g, new_len, m;
    nx = mx[0];
    ny = my[0];
    wh = 1'b0;
    sh = 1'b0;
    case (d)
      0: nx = nx + 1;
      1: ny = ny + 1;
      2: nx = nx - 1;
      default: ny = ny - 1;
    endcase
`ifdef SGA_WRAP_EN
    nx = (nx + GX) % GX;
    ny = (ny + GY) % GY;
`else
    if (nx < 0 || nx >= GX || ny < 0 || ny >= GY) begin
      wh  = 1'b1;
      lat = 2;
      return;
    end
`endif
    g = (gr && mx.size() < MAXL) ? 1 : 0;
    k = g ? mx.size() : mx.size() - 1;
    for (int j = 0; j < k; j++) begin
      if (mx[j] == nx && my[j] == ny) begin
        sh  = 1'b1;
        lat = j + 3;
        return;
      end
    end
    new_len = mx.size() + g;
    m = new_len - 1;
    lat = k + m + 3;
    mx.push_front(nx);
    my.push_front(ny);
    if (g == 0) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
  endtask

  // Compare status outputs and every body entry (via the read port) to the model.
  task automatic check_state(input string tag);
    int sz;
    sz = mx.size();
    check_eq({tag, "_length"}, length, sz);
    check_eq({tag, "_full"}, full, (sz == MAXL));
    check_eq({tag, "_head_x"}, head_x, mx[0]);
    check_eq({tag, "_head_y"}, head_y, my[0]);
    check_eq({tag, "_busy"}, busy, 0);
    for (int i = 0; i < MAXL; i++) begin
      @(negedge clock);
      rd_addr = 4'(i);
      @(negedge clock);
      check_eq($sformatf("%s_rd_valid[%0d]", tag, i), rd_valid, (i < sz));
      if (i < sz) begin
        check_eq($sformatf("%s_rd_data[%0d]", tag, i), rd_data, (mx[i] * 16) + my[i]);
      end
    end
  endtask

  task automatic do_init(input bit with_step, input string tag);
    int cnt;
    bit dseen;
    @(negedge clock);
    init = 1'b1;
    step = with_step;
    dir  = 2'($urandom_range(0, 3));
    @(posedge clock);
    #1;
    init = 1'b0;
    step = 1'b0;
    cnt = 0;
    dseen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) dseen = 1'b1;
      if (!busy) break;
      cnt++;
    end
    check_eq({tag, "_busy_cycles"}, cnt, ILEN);
    check_eq({tag, "_no_done"}, dseen, 0);
    mx.delete();
    my.delete();
    for (int i = 0; i < ILEN; i++) begin
      mx.push_back(IX - i);
      my.push_back(IY);
    end
    check_state(tag);
  endtask

  task automatic do_step(input int d, input bit gr, input bit poke, input bit full_check,
                         input string tag);
    int lat, cyc;
    bit wh, sh, seen;
    model_step(d, gr, lat, wh, sh);
    @(negedge clock);
    step = 1'b1;
    dir  = 2'(d);
    grow = gr;
    @(posedge clock);
    #1;
    step = 1'b0;
    dir  = 2'($urandom_range(0, 3));
    grow = 1'($urandom_range(0, 1));
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 200 && !seen) begin
      @(negedge clock);
      cyc++;
      if (poke && cyc == 1) begin
        step = 1'b1;
        dir  = 2'($urandom_range(0, 3));
        grow = 1'b1;
      end
      if (cyc == 2) step = 1'b0;
      if (done) seen = 1'b1;
    end
    step = 1'b0;
    check_eq({tag, "_done_cycle"}, seen ? cyc : 999, lat);
    check_eq({tag, "_wall_hit"}, wall_hit, wh);
    check_eq({tag, "_self_hit"}, self_hit, sh);
    @(negedge clock);
    check_eq({tag, "_done_pulse"}, done, 0);
    check_eq({tag, "_wall_hold"}, wall_hit, wh);
    check_eq({tag, "_self_hold"}, self_hit, sh);
    if (full_check) check_state(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit dseen;
    restart_n = 1'b0;
    init      = 1'b0;
    step      = 1'b0;
    dir       = 2'b00;
    grow      = 1'b0;
    rd_addr   = 4'd0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wall", wall_hit, 0);
    check_eq("rst_self", self_hit, 0);
    check_eq("rst_length", length, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_head", {head_x, head_y}, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    restart_n = 1'b1;

    // Start pose, then the two directed moves
    do_init(1'b0, "init");
    do_step(0, 1'b0, 1'b0, 1'b1, "right");
    do_step(1, 1'b1, 1'b0, 1'b1, "down_grow");
    // Run to the right edge, then push into it
    for (int i = 0; i < 9; i++) do_step(0, 1'b0, 1'b0, 1'b0, "to_edge");
    check_state("at_edge");
    do_step(0, 1'b0, 1'b1, 1'b1, "edge_right");

    // Build the coiled 5-long body and bite entry 3
    do_init(1'b0, "init2");
    do_step(0, 1'b0, 1'b0, 1'b0, "coil_r");
    do_step(1, 1'b0, 1'b0, 1'b0, "coil_d");
    do_step(2, 1'b0, 1'b0, 1'b0, "coil_l");
    do_step(2, 1'b1, 1'b0, 1'b0, "coil_lg");
    do_step(3, 1'b1, 1'b0, 1'b0, "coil_ug");
    do_step(0, 1'b0, 1'b0, 1'b1, "coil_rt");
    do_step(1, 1'b0, 1'b1, 1'b1, "bite");

    // Grow to maximum length, then one more grow request while full
    do_init(1'b0, "init3");
    for (int i = 0; i < 10; i++) do_step(0, 1'b1, 1'b0, 1'b0, "grow_r");
    for (int i = 0; i < 3; i++) do_step(1, 1'b1, 1'b0, 1'b0, "grow_d");
    check_state("at_full");
    do_step(1, 1'b1, 1'b1, 1'b1, "grow_full");

    // Reset in the middle of the body shift aborts without done
    do_init(1'b0, "init4");
    @(negedge clock);
    step = 1'b1;
    dir  = 2'b00;
    grow = 1'b0;
    @(posedge clock);
    #1;
    step = 1'b0;
    repeat (4) @(negedge clock);
    restart_n = 1'b0;
    dseen = 1'b0;
    @(negedge clock);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_length", length, 0);
    check_eq("abort_head", {head_x, head_y}, 0);
    if (done) dseen = 1'b1;
    restart_n = 1'b1;
    cyc = 0;
    while (cyc < 12) begin
      @(negedge clock);
      cyc++;
      if (done) dseen = 1'b1;
    end
    check_eq("abort_no_done", dseen, 0);
    check_eq("abort_idle", busy, 0);

    // init and step on the same edge: init wins
    do_init(1'b1, "init_step");

    // Random moves
    for (int n = 0; n < 150; n++) begin
      do_step($urandom_range(0, 3), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), 1'b1, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sga_body_sequencer.md
Name: sga_body_sequencer

Overview:
- Parametrised snake-body engine: owns the body coordinate store and performs one complete move per `step` request.
- Each move: next-head computation, wall check, self-collision scan, body shift, head write, optional growth.
- Replaces the control unit's hard-wired MOVE/WRITE_RAM/COMPARA_RAM/CONTA_RAM and COMPARA_SELF/CONTA_SELF loops with one self-timed block.
- Grid size, maximum length and start pose are generic.

Parameters:
- COORD_W, 4, bits per coordinate (x and y each).
- GRID_X, 16, columns; legal x is 0..GRID_X-1.
- GRID_Y, 16, rows; legal y is 0..GRID_Y-1.
- ADDR_W, 4, body index width; MAX_LEN = 2**ADDR_W.
- INIT_LEN, 3, length after `init`; range 1..MAX_LEN.
- INIT_X, 5, head x after `init`.
- INIT_Y, 8, head y after `init`.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- restart_n  in  1  synchronous active-low reset.
- init  in  1  pulse: load start snake.
- step  in  1  pulse: perform one move.
- dir  in  2  move direction: 00 right, 01 down, 10 left, 11 up.
- grow  in  1  sampled with `step`: lengthen by one this move.
- busy  out  1  high from the cycle after an accepted `init`/`step` until return to IDLE.
- done  out  1  one-cycle pulse at end of every `step`.
- wall_hit  out  1  valid with `done`; next head left the grid.
- self_hit  out  1  valid with `done`; next head hit the body.
- full  out  1  length == MAX_LEN.
- length  out  ADDR_W+1  current body length.
- head_x  out  COORD_W  entry 0 x.
- head_y  out  COORD_W  entry 0 y.
- rd_addr  in  ADDR_W  render read index.
- rd_data  out  2*COORD_W  {x,y} of entry rd_addr, registered, 1-cycle latency.
- rd_valid  out  1  registered: rd_addr < length.

Behaviour:
- Reset (restart_n=0 at an edge):
  - state IDLE; all outputs 0, including length, head and rd_*.
  - Body store is not cleared.
  - Reset in any state aborts the operation with no `done`.
- Storage: MAX_LEN registers; entry 0 is the head.
- Command acceptance:
  - `init`/`step` are accepted only in IDLE and ignored while busy.
  - `init` and `step` on the same edge: `init` wins.
- INIT: writes entry i = (INIT_X-i, INIT_Y), one per cycle, i = 0..INIT_LEN-1.
  - length = INIT_LEN when finished; back to IDLE; no `done`.
- STEP states: CALC -> SCAN -> SHIFT -> WHEAD -> DONE -> IDLE.
- CALC (1 cycle):
  - nh = head ±1 per `dir`; dir and grow are latched.
  - Wall hit when moving right at x=GRID_X-1, left at x=0, up at y=0, or down at y=GRID_Y-1.
  - On wall hit: go to DONE.
- SCAN:
  - Compares nh with entries 0..k-1, one per cycle.
  - k = length if growing, otherwise length-1 (the tail vacates).
  - k=0 skips SCAN.
  - A match on entry j ends the scan: next state DONE with self_hit.
- Growing: g = grow && !full. grow while full is treated as no-grow and length stays MAX_LEN.
- SHIFT: m = new_len-1 cycles, with new_len = length+g. Copies entry i-1 into entry i for i = new_len-1 down to 1.
- WHEAD (1 cycle): entry 0 = nh; length = new_len.
- DONE (1 cycle):
  - done=1; wall_hit/self_hit hold their flags until the next accepted `step`, then clear.
  - On any hit, the body and length are unchanged.
- Latency, with `step` sampled at edge E0:
  - Clean move: done is high in cycle E0+k+m+3.
  - Wall hit: done at E0+2.
  - Self hit on entry j: done at E0+j+3.
- full is combinational from length; head_x/head_y always reflect entry 0.

Optional Feature:
- Macro SGA_WRAP_EN.
- Defined: no wall collision; nh wraps modulo GRID_X/GRID_Y (right from GRID_X-1 gives 0, up from 0 gives GRID_Y-1). wall_hit is tied 0 and the move proceeds to SCAN.
- Undefined: wall collision as specified above.

Test Plan:
- Reset, then `init` -> busy for 3 cycles, then length=3, head=(5,8); rd_addr=2 gives rd_data=(3,8), rd_valid=1 on the next cycle; rd_addr=3 gives rd_valid=0.
- After `init`, `step` dir=00 grow=0 -> done at E0+7; body (6,8),(5,8),(4,8); length 3; both hit flags 0.
- Then `step` dir=01 grow=1 -> done at E0+9; head (6,9); length 4; entry 3 = (4,8).
- Move head to x=15 and `step` dir=00:
  - Without the macro: done at E0+2, wall_hit=1, body unchanged.
  - With SGA_WRAP_EN: head x=0, wall_hit=0.
- Length 5 body (5,8),(4,8),(4,9),(5,9),(6,9), `step` dir=01 grow=0 -> self_hit=1 at entry 3, done at E0+6, body unchanged.
- Grow to MAX_LEN=16 and `step` grow=1 -> length stays 16, full=1.
- `step` while busy is ignored.
- restart_n=0 during SHIFT -> next cycle IDLE, length 0, no `done`.
